hood_mode_ctrl: RTL and testbench
=================================

# hood_mode_ctrl

Top-level mode sequencer for the range-hood controller. Turns debounced front-panel buttons and a 1 Hz tick into power state, fan level, hurricane and cooldown countdowns, and the self-clean request. It owns the single fan/clean resource, so fan running and self-cleaning are mutually exclusive. It sits between the button/debounce layer and the self-clean and display blocks.

## Interface
- LONG_PRESS_SEC, 3: ticks `btn_power` must be held to toggle power
- HURRICANE_SEC, 60: hurricane run time, in ticks
- COOL_SEC, 60: level-2 extraction time after hurricane is aborted, in ticks
- IDLE_OFF_SEC, 10: STANDBY inactivity timeout, in ticks (used only with HOOD_AUTO_OFF_EN)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- tick  in  1  one-cycle pulse, once per second
- btn_power  in  1  debounced level; high while held
- btn_menu, btn_l1, btn_l2, btn_l3, btn_clean  in  1 each  one-cycle pulses
- clean_done  in  1  one-cycle pulse from the self-clean unit
- is_on  out  1  high in every state except OFF
- fan_level  out  2  0 = off, 1, 2, 3 = hurricane
- clean_req  out  1  level; high throughout CLEAN
- hurricane_used  out  1  hurricane already consumed this power cycle
- remain  out  8  seconds left in HURRICANE or COOLDOWN; 0 otherwise
- state_code  out  3  current state encoding, for the display

## Operation
- States: OFF, STANDBY, RUN, HURRICANE, COOLDOWN, CLEAN.
- Long-press detector:
  - Counts ticks while `btn_power` is high; clears when it goes low.
  - Fires one-cycle `lp` when the count reaches LONG_PRESS_SEC.
  - Fires at most once per press; the button must be released before it can fire again.
- Event priority within one cycle: lp > btn_menu > btn_l3 > btn_l2 > btn_l1 > btn_clean. Only the winning event is acted on.
- OFF:
  - lp -> STANDBY.
  - All other inputs ignored.
- STANDBY:
  - btn_l1 or btn_l2 -> RUN at that level.
  - btn_l3 with hurricane_used=0 -> HURRICANE; btn_l3 with hurricane_used=1 is ignored.
  - btn_clean -> CLEAN.
  - lp -> OFF.
- RUN:
  - btn_l1 / btn_l2 change fan_level.
  - btn_l3 behaves as in STANDBY.
  - btn_menu -> STANDBY.
  - btn_clean ignored.
  - lp -> OFF.
- HURRICANE:
  - On entry: remain=HURRICANE_SEC, hurricane_used=1, fan_level=3.
  - Each tick decrements remain.
  - Tick that takes remain 1->0 -> RUN at level 2.
  - btn_menu -> COOLDOWN.
  - Level and clean buttons ignored.
  - lp -> OFF.
- COOLDOWN:
  - On entry: remain=COOL_SEC, fan_level=2.
  - Each tick decrements remain; at 0 -> STANDBY.
  - All buttons ignored except lp -> OFF.
- CLEAN:
  - fan_level=0, clean_req=1.
  - clean_done -> STANDBY and clears hurricane_used.
  - lp -> OFF; clean_req drops in the same cycle the state changes.
- Entering OFF:
  - Clears hurricane_used and remain.
  - Sets fan_level=0.
- fan_level in STANDBY and OFF is 0.

## Timing
- All outputs are registered. They reflect an event in the cycle after the event's input pulse.
- remain load on entry takes precedence over a tick arriving in the same cycle.
- Button and tick in the same cycle: the state transition wins; the tick is not applied to the old state's counter.
- clean_done outside CLEAN is ignored.
- Countdowns decrement only on tick. remain never wraps below 0.
- Reset values:
  - state = OFF
  - is_on = 0, fan_level = 0, clean_req = 0, hurricane_used = 0, remain = 0
  - state_code = OFF encoding
  - long-press count = 0, armed
- Reset mid-operation aborts immediately. clean_req falls asynchronously with rst.

## Configuration
- Macro: HOOD_AUTO_OFF_EN.
- Defined:
  - STANDBY keeps an inactivity counter, cleared by any button event or by STANDBY entry.
  - When the counter reaches IDLE_OFF_SEC ticks, the block goes to OFF.
- Undefined: the counter and its logic are absent, and STANDBY persists indefinitely.

## Structure
- Package hood_pkg holds:
  - the state enum and its state_code encodings
  - fan-level constants: FAN_OFF, FAN_L1, FAN_L2, FAN_HURR
- Sub-module hood_press_timer: the long-press detector (tick counter plus release-rearm latch), parameterised by LONG_PRESS_SEC.

## Test plan
- Hold btn_power for 3 ticks from OFF -> is_on=1 and STANDBY one cycle after the 3rd tick. Keep holding for 3 more ticks -> stays in STANDBY (no refire).
- STANDBY, btn_l3 -> fan_level=3, remain=60. After 60 ticks -> RUN with fan_level=2. A second btn_l3 is ignored while hurricane_used=1.
- HURRICANE with remain=25, btn_menu -> COOLDOWN, remain=60, fan_level=2. After 60 ticks -> STANDBY with fan_level=0.
- STANDBY, btn_clean -> clean_req=1. clean_done -> STANDBY, clean_req=0, hurricane_used=0.
- btn_l2 and btn_l3 in the same cycle in STANDBY with hurricane_used=0 -> HURRICANE. btn_menu together with a tick in HURRICANE -> COOLDOWN with remain=60 (no decrement).
- With HOOD_AUTO_OFF_EN: STANDBY with no buttons for 10 ticks -> OFF. rst asserted during CLEAN -> clean_req=0 immediately.

Source files
------------

// File: rtl/hood_pkg.sv
// Shared types and constants for the range-hood mode controller.
// State encodings double as the display state_code.
package hood_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_STANDBY   = 3'd1,
        ST_RUN       = 3'd2,
        ST_HURRICANE = 3'd3,
        ST_COOLDOWN  = 3'd4,
        ST_CLEAN     = 3'd5
    } hood_state_t;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_LP,
        EV_MENU,
        EV_L3,
        EV_L2,
        EV_L1,
        EV_CLEAN
    } hood_event_t;

    localparam logic [1:0] FAN_OFF  = 2'd0;
    localparam logic [1:0] FAN_L1   = 2'd1;
    localparam logic [1:0] FAN_L2   = 2'd2;
    localparam logic [1:0] FAN_HURR = 2'd3;

    // Only the highest-priority event of a cycle is ever acted on.
    function automatic hood_event_t pick_event(input logic lp, input logic menu,
                                               input logic l3, input logic l2,
                                               input logic l1, input logic clean);
        if (lp)         return EV_LP;
        else if (menu)  return EV_MENU;
        else if (l3)    return EV_L3;
        else if (l2)    return EV_L2;
        else if (l1)    return EV_L1;
        else if (clean) return EV_CLEAN;
        else            return EV_NONE;
    endfunction

endpackage

// File: rtl/hood_press_timer.sv
// Long-press detector: counts ticks while btn_power is held and pulses lp
// once per press; releasing the button rearms it.
module hood_press_timer #(
    parameter int unsigned LONG_PRESS_SEC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_power,
    output logic lp
);

    localparam int unsigned CW = $clog2(LONG_PRESS_SEC + 1);

    logic [CW-1:0] cnt;
    logic          armed;

    // Fires on the tick that brings the count up to LONG_PRESS_SEC.
    assign lp = btn_power && tick && armed && (cnt == CW'(LONG_PRESS_SEC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else if (!btn_power) begin
            cnt   <= '0;
            armed <= 1'b1;
        end else begin
            if (lp)
                armed <= 1'b0;
            if (tick && cnt != CW'(LONG_PRESS_SEC))
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode sequencer: power, fan level, hurricane/cooldown countdowns
// and self-clean request. Optional STANDBY auto-off via HOOD_AUTO_OFF_EN.
module hood_mode_ctrl
    import hood_pkg::*;
#(
    parameter int unsigned LONG_PRESS_SEC = 3,
    parameter int unsigned HURRICANE_SEC  = 60,
    parameter int unsigned COOL_SEC       = 60,
    parameter int unsigned IDLE_OFF_SEC   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_power,
    input  logic       btn_menu,
    input  logic       btn_l1,
    input  logic       btn_l2,
    input  logic       btn_l3,
    input  logic       btn_clean,
    input  logic       clean_done,
    output logic       is_on,
    output logic [1:0] fan_level,
    output logic       clean_req,
    output logic       hurricane_used,
    output logic [7:0] remain,
    output logic [2:0] state_code
);

    localparam logic [7:0] HURR_LOAD = 8'(HURRICANE_SEC);
    localparam logic [7:0] COOL_LOAD = 8'(COOL_SEC);

    hood_state_t state, nxt_state;
    hood_event_t ev;
    logic        lp;
    logic [1:0]  nxt_fan;
    logic [7:0]  nxt_remain;
    logic        nxt_used;

    hood_press_timer #(
        .LONG_PRESS_SEC(LONG_PRESS_SEC)
    ) u_press (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .btn_power(btn_power),
        .lp       (lp)
    );

    assign ev = pick_event(lp, btn_menu, btn_l3, btn_l2, btn_l1, btn_clean);

`ifdef HOOD_AUTO_OFF_EN
    localparam int unsigned IW = $clog2(IDLE_OFF_SEC + 1);
    logic [IW-1:0] idle_cnt, nxt_idle;
`else
    generate
        if (IDLE_OFF_SEC == 0) begin : g_idle_unused
        end
    endgenerate
`endif

    always_comb begin
        nxt_state  = state;
        nxt_fan    = fan_level;
        nxt_remain = remain;
        nxt_used   = hurricane_used;
        if (ev == EV_LP) begin
            nxt_state  = (state == ST_OFF) ? ST_STANDBY : ST_OFF;
            nxt_fan    = FAN_OFF;
            nxt_remain = '0;
            nxt_used   = 1'b0;
        end else begin
            unique case (state)
                ST_OFF: ;
                ST_STANDBY, ST_RUN: begin
                    case (ev)
                        EV_MENU: if (state == ST_RUN) begin
                            nxt_state = ST_STANDBY;
                            nxt_fan   = FAN_OFF;
                        end
                        EV_L3: if (!hurricane_used) begin
                            nxt_state  = ST_HURRICANE;
                            nxt_fan    = FAN_HURR;
                            nxt_remain = HURR_LOAD;
                            nxt_used   = 1'b1;
                        end
                        EV_L2: begin
                            nxt_state = ST_RUN;
                            nxt_fan   = FAN_L2;
                        end
                        EV_L1: begin
                            nxt_state = ST_RUN;
                            nxt_fan   = FAN_L1;
                        end
                        EV_CLEAN: if (state == ST_STANDBY) begin
                            nxt_state = ST_CLEAN;
                            nxt_fan   = FAN_OFF;
                        end
`ifdef HOOD_AUTO_OFF_EN
                        EV_NONE: if (state == ST_STANDBY && tick &&
                                     idle_cnt == IW'(IDLE_OFF_SEC - 1)) begin
                            nxt_state  = ST_OFF;
                            nxt_fan    = FAN_OFF;
                            nxt_remain = '0;
                            nxt_used   = 1'b0;
                        end
`endif
                        default: ;
                    endcase
                end
                ST_HURRICANE: begin
                    if (ev == EV_MENU) begin
                        nxt_state  = ST_COOLDOWN;
                        nxt_fan    = FAN_L2;
                        nxt_remain = COOL_LOAD;
                    end else if (tick) begin
                        if (remain <= 8'd1) begin
                            nxt_state  = ST_RUN;
                            nxt_fan    = FAN_L2;
                            nxt_remain = '0;
                        end else begin
                            nxt_remain = remain - 8'd1;
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (tick) begin
                        if (remain <= 8'd1) begin
                            nxt_state  = ST_STANDBY;
                            nxt_fan    = FAN_OFF;
                            nxt_remain = '0;
                        end else begin
                            nxt_remain = remain - 8'd1;
                        end
                    end
                end
                ST_CLEAN: begin
                    if (clean_done) begin
                        nxt_state = ST_STANDBY;
                        nxt_used  = 1'b0;
                    end
                end
                default: begin
                    nxt_state  = ST_OFF;
                    nxt_fan    = FAN_OFF;
                    nxt_remain = '0;
                    nxt_used   = 1'b0;
                end
            endcase
        end
    end

`ifdef HOOD_AUTO_OFF_EN
    // Idle time only accumulates across quiet STANDBY cycles; entry or any button clears it.
    always_comb begin
        nxt_idle = '0;
        if (state == ST_STANDBY && nxt_state == ST_STANDBY && ev == EV_NONE &&
            !btn_menu && !btn_l1 && !btn_l2 && !btn_l3 && !btn_clean)
            nxt_idle = tick ? idle_cnt + 1'b1 : idle_cnt;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_OFF;
            fan_level      <= FAN_OFF;
            remain         <= '0;
            hurricane_used <= 1'b0;
            is_on          <= 1'b0;
            clean_req      <= 1'b0;
            state_code     <= ST_OFF;
`ifdef HOOD_AUTO_OFF_EN
            idle_cnt       <= '0;
`endif
        end else begin
            state          <= nxt_state;
            fan_level      <= nxt_fan;
            remain         <= nxt_remain;
            hurricane_used <= nxt_used;
            is_on          <= (nxt_state != ST_OFF);
            clean_req      <= (nxt_state == ST_CLEAN);
            state_code     <= nxt_state;
`ifdef HOOD_AUTO_OFF_EN
            idle_cnt       <= nxt_idle;
`endif
        end
    end

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed self-checking bench for hood_mode_ctrl; auto-off checks follow HOOD_AUTO_OFF_EN.
module tb_hood_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst, tick, btn_power, btn_menu, btn_l1, btn_l2, btn_l3, btn_clean, clean_done;
    logic       is_on, clean_req, hurricane_used;
    logic [1:0] fan_level;
    logic [7:0] remain;
    logic [2:0] state_code;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] S_OFF = 3'd0, S_STBY = 3'd1, S_RUN = 3'd2,
                           S_HURR = 3'd3, S_COOL = 3'd4, S_CLEAN = 3'd5;

    always #5 clk = ~clk;

    hood_mode_ctrl #(
        .LONG_PRESS_SEC(3),
        .HURRICANE_SEC (60),
        .COOL_SEC      (60),
        .IDLE_OFF_SEC  (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .btn_power     (btn_power),
        .btn_menu      (btn_menu),
        .btn_l1        (btn_l1),
        .btn_l2        (btn_l2),
        .btn_l3        (btn_l3),
        .btn_clean     (btn_clean),
        .clean_done    (clean_done),
        .is_on         (is_on),
        .fan_level     (fan_level),
        .clean_req     (clean_req),
        .hurricane_used(hurricane_used),
        .remain        (remain),
        .state_code    (state_code)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Applies the currently driven pulses for one edge, then clears them.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick = 0; btn_menu = 0; btn_l1 = 0; btn_l2 = 0; btn_l3 = 0;
        btn_clean = 0; clean_done = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1;
            cyc();
        end
    endtask

    task automatic long_press();
        btn_power = 1;
        ticks(3);
        btn_power = 0;
        cyc();
    endtask

    initial begin
        rst = 1; tick = 0; btn_power = 0; btn_menu = 0; btn_l1 = 0; btn_l2 = 0;
        btn_l3 = 0; btn_clean = 0; clean_done = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state_code, S_OFF);
        check("rst_is_on", is_on, 0);
        check("rst_fan", fan_level, 0);
        check("rst_clean_req", clean_req, 0);
        check("rst_used", hurricane_used, 0);
        check("rst_remain", remain, 0);
        rst = 0;
        cyc();

        // OFF ignores level buttons
        btn_l1 = 1; cyc();
        check("off_ignore_l1", state_code, S_OFF);

        // Long press from OFF
        btn_power = 1;
        ticks(2);
        check("lp_not_yet", is_on, 0);
        ticks(1);
        check("lp_on", is_on, 1);
        check("lp_standby", state_code, S_STBY);
        ticks(3);
        check("lp_no_refire", state_code, S_STBY);
        btn_power = 0; cyc();

        // Menu outranks l1 and does nothing in STANDBY
        btn_menu = 1; btn_l1 = 1; cyc();
        check("prio_menu_l1", state_code, S_STBY);

        // Hurricane full run
        btn_l3 = 1; cyc();
        check("hurr_state", state_code, S_HURR);
        check("hurr_fan", fan_level, 3);
        check("hurr_remain", remain, 60);
        check("hurr_used", hurricane_used, 1);
        btn_l1 = 1; tick = 1; cyc();
        check("hurr_ignore_l1", remain, 59);
        ticks(58);
        check("hurr_last", remain, 1);
        check("hurr_last_state", state_code, S_HURR);
        ticks(1);
        check("hurr_end_state", state_code, S_RUN);
        check("hurr_end_fan", fan_level, 2);
        check("hurr_end_remain", remain, 0);
        btn_l3 = 1; cyc();
        check("l3_used_state", state_code, S_RUN);
        btn_l1 = 1; cyc();
        check("run_l1_fan", fan_level, 1);
        btn_clean = 1; cyc();
        check("run_ignore_clean", state_code, S_RUN);
        btn_menu = 1; cyc();
        check("run_menu_state", state_code, S_STBY);
        check("run_menu_fan", fan_level, 0);
        btn_l3 = 1; cyc();
        check("stby_l3_used", state_code, S_STBY);

        // Self clean clears hurricane_used
        btn_clean = 1; cyc();
        check("clean_state", state_code, S_CLEAN);
        check("clean_req_on", clean_req, 1);
        check("clean_fan", fan_level, 0);
        btn_l1 = 1; cyc();
        check("clean_ignore_l1", state_code, S_CLEAN);
        clean_done = 1; cyc();
        check("cdone_state", state_code, S_STBY);
        check("cdone_req", clean_req, 0);
        check("cdone_used", hurricane_used, 0);

        // l2 + l3 together -> hurricane; menu + tick -> cooldown, no decrement
        btn_l2 = 1; btn_l3 = 1; cyc();
        check("l2l3_state", state_code, S_HURR);
        check("l2l3_fan", fan_level, 3);
        ticks(35);
        check("hurr_25", remain, 25);
        btn_menu = 1; tick = 1; cyc();
        check("cool_state", state_code, S_COOL);
        check("cool_remain", remain, 60);
        check("cool_fan", fan_level, 2);
        btn_l1 = 1; btn_menu = 1; cyc();
        check("cool_ignore_btn", state_code, S_COOL);
        ticks(59);
        check("cool_last", remain, 1);
        ticks(1);
        check("cool_end_state", state_code, S_STBY);
        check("cool_end_fan", fan_level, 0);
        check("cool_end_remain", remain, 0);

        // clean_done outside CLEAN
        clean_done = 1; cyc();
        check("cdone_outside", state_code, S_STBY);

`ifdef HOOD_AUTO_OFF_EN
        ticks(9);
        check("idle_9", state_code, S_STBY);
        ticks(1);
        check("idle_off", state_code, S_OFF);
        check("idle_off_on", is_on, 0);
        long_press();
`else
        ticks(12);
        check("idle_persist", state_code, S_STBY);
`endif

        // Long press in STANDBY -> OFF
        long_press();
        check("lp_off_state", state_code, S_OFF);
        check("lp_off_is_on", is_on, 0);
        clean_done = 1; cyc();
        check("off_ignore_cdone", state_code, S_OFF);

        // Long press in CLEAN -> OFF, clean_req drops with it
        long_press();
        btn_clean = 1; cyc();
        check("clean2_req", clean_req, 1);
        btn_power = 1;
        ticks(3);
        check("clean_lp_state", state_code, S_OFF);
        check("clean_lp_req", clean_req, 0);
        btn_power = 0; cyc();

        // Asynchronous reset during CLEAN
        long_press();
        btn_clean = 1; cyc();
        check("clean3_req", clean_req, 1);
        #2;
        rst = 1;
        #1;
        check("async_rst_req", clean_req, 0);
        check("async_rst_state", state_code, S_OFF);
        cyc();
        rst = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
